// File: rtl/sort_out_serializer.sv
// Streams one sorted frame from the merge network out as single keys, lowest index first.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   in_valid/in_ready  frame handshake; in_ready is high only while idle
//   in_data            2*n keys, key k at bits [(k+1)*WIDTH-1 : k*WIDTH]
//   in_count           number of meaningful keys from key 0 (values above 2*n clamp to 2*n)
//   out_valid/out_ready per-key handshake
//   out_data           current key
//   out_index          position of the current key within the frame
//   out_last           current key is the final one of the frame
module sort_out_serializer #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned n     = 64,
    localparam int unsigned DEPTH = 2 * n,
    localparam int unsigned CW    = $clog2(DEPTH) + 1,
    localparam int unsigned IW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DEPTH*WIDTH-1:0] in_data,
    input  logic [CW-1:0]          in_count,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [IW-1:0]          out_index,
    output logic                   out_last
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [DEPTH*WIDTH-1:0] frame_q, frame_d;
    logic [IW-1:0]          idx_q, idx_d, idx_inc;
    logic [CW-1:0]          len_q, len_d, len_clamp;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_last_q, out_last_d;
    logic [WIDTH-1:0]       out_data_q, out_data_d;
    logic [WIDTH-1:0]       key [DEPTH];

    // Unpacked view of the stored frame so the current key is a plain array lookup.
    for (genvar k = 0; k < DEPTH; k++) begin : g_key
        assign key[k] = frame_q[k*WIDTH +: WIDTH];
    end

    assign len_clamp = (in_count > CW'(DEPTH)) ? CW'(DEPTH) : in_count;
    assign idx_inc   = idx_q + IW'(1);

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        idx_d       = idx_q;
        len_d       = len_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;

        unique case (state_q)
            IDLE: begin
                // A zero-length frame is consumed without producing any beat.
                if (in_valid && in_ready_q && (in_count != '0)) begin
                    state_d     = STREAM;
                    frame_d     = in_data;
                    len_d       = len_clamp;
                    idx_d       = '0;
                    out_valid_d = 1'b1;
                    out_data_d  = in_data[WIDTH-1:0];
                    out_last_d  = (len_clamp == CW'(1));
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (out_last_q) begin
                        state_d     = IDLE;
                        idx_d       = '0;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        idx_d      = idx_inc;
                        out_data_d = key[idx_inc];
                        out_last_d = (CW'(idx_inc) == (len_q - CW'(1)));
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    // Frame storage needs no reset: it is only read while a captured frame is streaming.
    always_ff @(posedge clk) begin
        frame_q <= frame_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = idx_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_sort_out_serializer.sv
module tb_sort_out_serializer;

    localparam int unsigned WIDTH = 3;
    localparam int unsigned N     = 64;
    localparam int unsigned DEPTH = 2 * N;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam int unsigned IW    = $clog2(DEPTH);

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [DEPTH*WIDTH-1:0] in_data;
    logic [CW-1:0]          in_count;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;
    logic [IW-1:0]          out_index;
    logic                   out_last;

    int n_cmp = 0;
    int n_bad = 0;
    int keys [DEPTH];

    sort_out_serializer #(.WIDTH(WIDTH), .n(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_count  (in_count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_keys();
        for (int k = 0; k < DEPTH; k++) in_data[k*WIDTH +: WIDTH] = WIDTH'(keys[k]);
    endtask

    // Presents one frame for a single edge, then scrambles the bus while the DUT streams.
    task automatic send_frame(input int count);
        chk("pre_in_ready", 32'(in_ready), 32'd1);
        load_keys();
        in_count = CW'(count);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = ~in_data;
        in_count = CW'(DEPTH);
    endtask

    // Consumes beats; optional stall before handshaking beat stall_at; returns early at beat stop_at.
    task automatic stream(input int exp_len, input int stall_at, input int stall_n, input int stop_at);
        int beat = 0;
        out_ready = 1'b1;
        while (beat < exp_len) begin
            if (beat == stop_at) return;
            chk("out_valid", 32'(out_valid), 32'd1);
            chk("out_data", 32'(out_data), 32'(keys[beat]));
            chk("out_index", 32'(out_index), 32'(beat));
            chk("out_last", 32'(out_last), 32'(beat == exp_len - 1));
            if (beat == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    tick();
                    chk("hold_valid", 32'(out_valid), 32'd1);
                    chk("hold_data", 32'(out_data), 32'(keys[beat]));
                    chk("hold_index", 32'(out_index), 32'(beat));
                    chk("hold_last", 32'(out_last), 32'(beat == exp_len - 1));
                end
                out_ready = 1'b1;
            end
            tick();
            beat++;
        end
        chk("end_out_valid", 32'(out_valid), 32'd0);
        chk("end_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_count  = '0;
        out_ready = 1'b1;

        // Reset state.
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_index", 32'(out_index), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Full frame, keys k mod 8.
        for (int k = 0; k < DEPTH; k++) keys[k] = k % 8;
        send_frame(128);
        stream(128, -1, 0, -1);

        // Partial frame 0,1,1,3,7.
        keys[0] = 0; keys[1] = 1; keys[2] = 1; keys[3] = 3; keys[4] = 7;
        for (int k = 5; k < DEPTH; k++) keys[k] = 7;
        send_frame(5);
        stream(5, -1, 0, -1);

        // Backpressure: 3 stall cycles at index 10, ascending keys k/16.
        for (int k = 0; k < DEPTH; k++) keys[k] = k / 16;
        send_frame(128);
        stream(128, 10, 3, -1);

        // Zero-length frame: consumed, no beat.
        send_frame(0);
        chk("zero_out_valid", 32'(out_valid), 32'd0);
        chk("zero_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("zero_out_valid2", 32'(out_valid), 32'd0);
        chk("zero_in_ready2", 32'(in_ready), 32'd1);

        // Oversized count clamps to 128.
        for (int k = 0; k < DEPTH; k++) keys[k] = (k * 5) / 128;
        send_frame(200);
        stream(128, -1, 0, -1);

        // Single-key frame.
        keys[0] = 6;
        send_frame(1);
        stream(1, -1, 0, -1);

        // Reset mid-frame at index 40, then a fresh frame.
        for (int k = 0; k < DEPTH; k++) keys[k] = k % 8;
        send_frame(128);
        stream(128, -1, 0, 40);
        chk("abort_index", 32'(out_index), 32'd40);
        rst = 1'b1;
        tick();
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        tick();
        chk("abort_in_ready_after", 32'(in_ready), 32'd1);
        chk("abort_out_valid_after", 32'(out_valid), 32'd0);
        keys[0] = 2; keys[1] = 4; keys[2] = 5;
        send_frame(3);
        stream(3, -1, 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sort_out_serializer.md
SORT_OUT_SERIALIZER -- requirements
Module: sort_out_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 3, meaning bit width of one sorted key.
REQ-002 SHALL have parameter n, default 64, meaning half the frame size; a frame holds 2*n keys.
REQ-003 SHALL derive CW = clog2(2*n)+1 (8 at defaults) as the count width and IW = clog2(2*n) (7 at defaults) as the index width.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: sorted frame present on in_data.
REQ-007 SHALL have port in_ready, output, 1 bit: block can accept a frame.
REQ-008 SHALL have port in_data, input, 2*n*WIDTH bits: ascending sorted vector from the merge network; key k at bits [(k+1)*WIDTH-1 : k*WIDTH].
REQ-009 SHALL have port in_count, input, CW bits: number of meaningful keys in the frame, counted from key 0.
REQ-010 SHALL have port out_valid, output, 1 bit: out_data holds a key.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts the key.
REQ-012 SHALL have port out_data, output, WIDTH bits: current key.
REQ-013 SHALL have port out_index, output, IW bits: position of the current key in the frame.
REQ-014 SHALL have port out_last, output, 1 bit: current key is the final key of the frame.

Function
REQ-015 SHALL implement two states: IDLE and STREAM.
REQ-016 SHALL drive in_ready=1 only in IDLE; in_ready=0 throughout STREAM.
REQ-017 SHALL, in IDLE on in_valid&in_ready with in_count>=1: register in_data, register min(in_count, 2*n) as len, set idx=0, and enter STREAM.
REQ-018 SHALL, in IDLE on in_valid&in_ready with in_count=0: consume the frame, emit no beat, and stay in IDLE.
REQ-019 SHALL clamp in_count values above 2*n to 2*n.
REQ-020 SHALL drive out_valid=1 in every STREAM cycle and 0 in IDLE.
REQ-021 SHALL drive out_data = stored key[idx], out_index = idx, and out_last = (idx == len-1) in STREAM.
REQ-022 SHALL give first-beat latency of exactly 1 cycle: out_valid rises in the cycle after the capture edge.
REQ-023 SHALL increment idx on out_valid&out_ready when out_last=0.
REQ-024 SHALL hold out_data, out_index and out_last stable while out_valid=1 and out_ready=0, for any duration.
REQ-025 SHALL return to IDLE on out_valid&out_ready&out_last; in_ready=1 in the following cycle.
REQ-026 SHALL take len+1 cycles per frame with out_ready held high: len data beats plus 1 IDLE capture cycle.
REQ-027 SHALL leave the stored frame unaffected by in_data or in_valid changes during STREAM.
REQ-028 SHALL emit keys unmodified, lowest index first, which is ascending order for a sorted input.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, force state=IDLE, idx=0, len=0, out_valid=0, out_last=0, out_data=0, out_index=0, in_ready=0 during the reset cycle and 1 from the first cycle after rst deasserts.
REQ-030 SHALL abort any frame in progress on rst mid-STREAM: no further beats, and the remaining keys are discarded.
REQ-031 SHALL give rst priority over every simultaneous handshake.

Verification
REQ-032 Full frame: keys k = k mod 8, in_count=128, out_ready=1 -> 128 beats; out_index 0..127, out_last only on beat 127, in_ready=1 on cycle 129.
REQ-033 Partial frame: in_count=5, keys 0,1,1,3,7,... -> exactly 5 beats with data 0,1,1,3,7, out_last on index 4.
REQ-034 Backpressure: out_ready low for 3 cycles at index 10 -> out_data/out_index/out_last held for those 3 cycles, no skipped or duplicated key.
REQ-035 Boundaries: in_count=0 -> no beats and in_ready stays 1; in_count=200 -> 128 beats; in_count=1 -> one beat with out_last=1.
REQ-036 Reset mid-frame: rst at index 40 -> out_valid=0 in the next cycle, in_ready=1 one cycle after rst deasserts, and a new frame streams from index 0.
